// File: rtl/uart_rx_pkg.sv
// Shared UART constants: baud counter end values and the derived mid-bit sample point.
// These must stay identical to the transmitter's constants.
package uart_rx_pkg;

  localparam int BAUD_END_BOARD = 5207;
  localparam int BAUD_END_SIM   = 56;
  localparam int BAUD_CNT_W     = 13;
  localparam int BIT_CNT_W      = 4;
  localparam int DATA_BITS      = 8;

  function automatic int baud_mid(input int baud_end);
    return baud_end / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous serial pin plus falling-edge detect.
// Flops reset to 1 so that an idle-high line produces no spurious edge.
module uart_rx_sync (
  input  logic sclk,
  input  logic s_rst,
  input  logic rs232_rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_s1;
  logic rx_s2;
  logic rx_s3;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rs232_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_sync = rx_s3;
  assign rx_fall = ~rx_s2 & rx_s3;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, mid-bit sampling of the synchronised input.
// Delivers each good byte with a one-cycle po_flag; a zero stop bit gives a one-cycle frame_err.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_END = BAUD_END_BOARD
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BAUD_M = baud_mid(BAUD_END);
  localparam logic [BAUD_CNT_W-1:0] BAUD_END_C = BAUD_CNT_W'(BAUD_END);
  localparam logic [BAUD_CNT_W-1:0] BAUD_M_C   = BAUD_CNT_W'(BAUD_M);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT   = BIT_CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic                  rx_sync;
  logic                  rx_fall;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [7:0]            shift_reg;
  logic                  at_mid;
  logic                  at_end;
  logic                  cnt_run;
  logic                  shift_en;
  logic                  load_data;
  logic                  flag_err;

  uart_rx_sync u_sync (
    .sclk     (sclk),
    .s_rst    (s_rst),
    .rs232_rx (rs232_rx),
    .rx_sync  (rx_sync),
    .rx_fall  (rx_fall)
  );

  assign at_mid = (baud_cnt == BAUD_M_C);
  assign at_end = (baud_cnt == BAUD_END_C);

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Leaving at the stop-bit midpoint gives half a bit of slack for the next start edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rx_fall) next_state = START;
      end
      START: begin
        if (at_mid && rx_sync) next_state = IDLE;
        else if (at_end)       next_state = DATA;
      end
      DATA: begin
        if (at_end && (bit_cnt == LAST_BIT)) next_state = STOP;
      end
      STOP: begin
        if (at_mid) next_state = rx_sync ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_sync) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_run   = (state == START) || (state == DATA) || (state == STOP);
    shift_en  = (state == DATA) && at_mid;
    load_data = (state == STOP) && at_mid && rx_sync;
    flag_err  = (state == STOP) && at_mid && !rx_sync;
    rx_busy   = (state != IDLE);
  end

  // The counter restarts on every state change so each phase begins at a fresh bit boundary.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      baud_cnt <= '0;
    end else if (!cnt_run || (next_state != state) || at_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      bit_cnt <= '0;
    end else if (state != DATA) begin
      bit_cnt <= '0;
    end else if (at_end) begin
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      shift_reg <= 8'h00;
    end else if (shift_en) begin
      shift_reg <= {rx_sync, shift_reg[7:1]};
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rx_data   <= 8'h00;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag   <= load_data;
      frame_err <= flag_err;
      if (load_data) rx_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus randomized frames with baud skew,
// checked against a byte-level reference model of expected deliveries and framing errors.
module tb_uart_rx;

  localparam int BIT_P   = 57;
  localparam int LAT_MIN = 9 * BIT_P + 27 + 4 - 1;
  localparam int LAT_MAX = 9 * BIT_P + 27 + 4 + 1;

  logic       sclk;
  logic       s_rst;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       po_flag;
  logic       frame_err;
  logic       rx_busy;

  int checks;
  int fails;
  int cyc;
  int po_count;
  int fe_count;
  int exp_po;
  int exp_fe;
  logic [7:0] model_rx;
  logic [7:0] exp_q[$];
  int         fall_q[$];
  logic       po_prev;
  logic       fe_prev;

  uart_rx #(.BAUD_END(56)) dut (
    .sclk      (sclk),
    .s_rst     (s_rst),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .po_flag   (po_flag),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_po_count"}, po_count, exp_po);
    checkOutput({tag, "_fe_count"}, fe_count, exp_fe);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_data"}, rx_data, 8'h00);
    checkOutput({tag, "_po_flag"}, po_flag, 1'b0);
    checkOutput({tag, "_frame_err"}, frame_err, 1'b0);
    checkOutput({tag, "_rx_busy"}, rx_busy, 1'b0);
  endtask

  // Sends one frame starting at the current negedge; a good stop bit means one delivered byte.
  task automatic applyStimulus(input logic [7:0] data, input logic stop, input bit expect_ok,
                               input int period);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    if (expect_ok) begin
      exp_q.push_back(data);
      fall_q.push_back(cyc);
      exp_po++;
    end
    if (!stop) exp_fe++;
    for (int i = 0; i < 10; i++) begin
      rs232_rx = frame[i];
      if (i == 1) checkOutput("busy_in_frame", rx_busy, 1'b1);
      repeat (period) @(negedge sclk);
    end
    rs232_rx = 1'b1;
  endtask

  // Strobe monitor: width, exclusivity, delivered byte, latency and hold-on-error.
  initial begin
    po_prev = 1'b0;
    fe_prev = 1'b0;
    forever begin
      @(negedge sclk);
      if (po_prev) checkOutput("po_width", po_flag, 1'b0);
      if (fe_prev) checkOutput("fe_width", frame_err, 1'b0);
      if (po_flag) begin
        po_count++;
        checkOutput("po_fe_exclusive", frame_err, 1'b0);
        if (exp_q.size() > 0) begin
          logic [7:0] exp_byte;
          int lat;
          exp_byte = exp_q.pop_front();
          lat = cyc - fall_q.pop_front();
          checkOutput("rx_data_on_po", rx_data, exp_byte);
          checkOutput($sformatf("po_latency_%0d_in_window", lat),
                      (lat >= LAT_MIN) && (lat <= LAT_MAX), 1);
          model_rx = exp_byte;
        end
      end
      if (frame_err) begin
        fe_count++;
        checkOutput("fe_rx_hold", rx_data, model_rx);
      end
      po_prev = po_flag;
      fe_prev = frame_err;
    end
  end

  initial begin
    checks = 0; fails = 0; po_count = 0; fe_count = 0; exp_po = 0; exp_fe = 0;
    model_rx = 8'h00;
    rs232_rx = 1'b1;
    s_rst = 1'b1;
    repeat (4) @(negedge sclk);
    checkResetValues("reset");
    s_rst = 1'b0;
    repeat (20) @(negedge sclk);

    $display("[TB] single frame 0x55");
    applyStimulus(8'h55, 1'b1, 1'b1, BIT_P);
    repeat (20) @(negedge sclk);
    checkCounts("t1");
    checkOutput("t1_rx_data", rx_data, 8'h55);
    checkOutput("t1_busy_idle", rx_busy, 1'b0);

    $display("[TB] back-to-back 0xA3, 0x0F");
    applyStimulus(8'hA3, 1'b1, 1'b1, BIT_P);
    applyStimulus(8'h0F, 1'b1, 1'b1, BIT_P);
    repeat (20) @(negedge sclk);
    checkCounts("t2");
    checkOutput("t2_rx_data", rx_data, 8'h0F);

    $display("[TB] start-bit glitch");
    rs232_rx = 1'b0;
    repeat (10) @(negedge sclk);
    checkOutput("t3_busy_start", rx_busy, 1'b1);
    repeat (10) @(negedge sclk);
    rs232_rx = 1'b1;
    repeat (60) @(negedge sclk);
    checkOutput("t3_busy_idle", rx_busy, 1'b0);
    checkCounts("t3");

    $display("[TB] bad stop bit 0x3C");
    applyStimulus(8'h3C, 1'b0, 1'b0, BIT_P);
    repeat (20) @(negedge sclk);
    checkCounts("t4");
    checkOutput("t4_rx_data_held", rx_data, 8'h0F);
    checkOutput("t4_busy_idle", rx_busy, 1'b0);

    $display("[TB] line break");
    rs232_rx = 1'b0;
    exp_fe++;
    repeat (15 * BIT_P) @(negedge sclk);
    checkOutput("t5_busy_in_break", rx_busy, 1'b1);
    checkCounts("t5_break");
    rs232_rx = 1'b1;
    repeat (20) @(negedge sclk);
    checkOutput("t5_busy_idle", rx_busy, 1'b0);
    checkCounts("t5_released");
    applyStimulus(8'h81, 1'b1, 1'b1, BIT_P);
    repeat (20) @(negedge sclk);
    checkCounts("t5");
    checkOutput("t5_rx_data", rx_data, 8'h81);

    $display("[TB] reset during bit 4 of 0xFF");
    fork
      applyStimulus(8'hFF, 1'b1, 1'b0, BIT_P);
      begin
        repeat (5 * BIT_P + 10) @(negedge sclk);
        s_rst = 1'b1;
        repeat (2) @(negedge sclk);
        checkResetValues("t6_reset");
        model_rx = 8'h00;
        s_rst = 1'b0;
      end
    join
    repeat (20) @(negedge sclk);
    checkCounts("t6_aborted");
    checkOutput("t6_rx_data_cleared", rx_data, 8'h00);
    applyStimulus(8'h12, 1'b1, 1'b1, BIT_P);
    repeat (20) @(negedge sclk);
    checkCounts("t6");
    checkOutput("t6_rx_data", rx_data, 8'h12);

    $display("[TB] randomized frames with baud skew");
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       stop;
      int         period;
      int         gap;
      d      = 8'($urandom);
      stop   = ($urandom_range(0, 4) != 0);
      period = $urandom_range(BIT_P - 1, BIT_P + 1);
      applyStimulus(d, stop, stop, period);
      gap = stop ? $urandom_range(0, 30) : $urandom_range(10, 30);
      repeat (gap) @(negedge sclk);
    end
    repeat (40) @(negedge sclk);
    checkCounts("rand");
    checkOutput("rand_rx_data", rx_data, model_rx);
    checkOutput("rand_busy_idle", rx_busy, 1'b0);
    checkOutput("rand_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
